// File: rtl/multicycle_controller.sv
// Multicycle RV32-style control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-wait timeout trap and retired-instruction counter.
module multicycle_controller #(
   parameter int INSTRET_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES  = 15,
   parameter int TRAP_ON_ILLEGAL = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [6:0]               opCode,
   input  logic [2:0]               funct3,
   input  logic                     branchTaken,
   input  logic                     memReady,
   output logic                     memReq,
   output logic                     PCWrite,
   output logic                     IRWrite,
   output logic                     DMemRead,
   output logic                     DMemWrite,
   output logic                     ALUOverride,
   output logic                     regFileWrite,
   output logic [1:0]               ALUSrcA,
   output logic [1:0]               ALUSrcB,
   output logic                     regFileWriteSrc,
   output logic                     trap,
   output logic [2:0]               state,
   output logic [INSTRET_WIDTH-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
   localparam logic [6:0] OP_ALU_REG = 7'b0110011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;

   localparam logic [1:0] SRC_REGOUT = 2'b00;
   localparam logic [1:0] SRC_PC     = 2'b01;
   localparam logic [1:0] SRC_ZERO   = 2'b10;
   localparam logic [1:0] SRC_IMMED  = 2'b01;
   localparam logic [1:0] SRC_CONST4 = 2'b10;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     st;
   logic       br_flag;
   logic [7:0] wait_cnt;
   logic       legal_op;
   logic       illegal;
   logic       ld, sto, br, jal, jalr;
   logic       timeout;

   always_comb begin
      legal_op = 1'b0;
      case (opCode)
         OP_LOAD, OP_STORE, OP_ALU_IMM, OP_ALU_REG, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
         default:                           legal_op = 1'b0;
      endcase
   end

   assign illegal = !legal_op
                  || (opCode == OP_LOAD   && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
                  || (opCode == OP_STORE  && funct3 > 3'd2)
                  || (opCode == OP_BRANCH && (funct3 == 3'd2 || funct3 == 3'd3));

   // Illegal encodings that retire as NOP must not touch memory or redirect the PC.
   assign ld   = (opCode == OP_LOAD)   && !illegal;
   assign sto  = (opCode == OP_STORE)  && !illegal;
   assign br   = (opCode == OP_BRANCH) && !illegal;
   assign jal  = (opCode == OP_JAL);
   assign jalr = (opCode == OP_JALR);

   assign state = st;

   always_comb begin
      memReq          = 1'b0;
      PCWrite         = 1'b0;
      IRWrite         = 1'b0;
      DMemRead        = 1'b0;
      DMemWrite       = 1'b0;
      ALUOverride     = 1'b0;
      regFileWrite    = 1'b0;
      ALUSrcA         = SRC_REGOUT;
      ALUSrcB         = SRC_REGOUT;
      regFileWriteSrc = 1'b0;
      trap            = 1'b0;
      case (st)
         S_FETCH: begin
            memReq  = 1'b1;
            IRWrite = memReady;
         end
         S_EXECUTE: begin
            case (opCode)
               OP_ALU_REG, OP_BRANCH: begin ALUSrcA = SRC_REGOUT; ALUSrcB = SRC_REGOUT; end
               OP_JAL, OP_JALR:       begin ALUSrcA = SRC_PC;     ALUSrcB = SRC_CONST4; end
               OP_LUI:                begin ALUSrcA = SRC_ZERO;   ALUSrcB = SRC_IMMED;  end
               OP_AUIPC:              begin ALUSrcA = SRC_PC;     ALUSrcB = SRC_IMMED;  end
               default:               begin ALUSrcA = SRC_REGOUT; ALUSrcB = SRC_IMMED;  end
            endcase
         end
         S_MEMORY: begin
            ALUOverride = 1'b1;
            if (jalr) begin
               ALUSrcA = SRC_REGOUT; ALUSrcB = SRC_IMMED;
            end else if (jal || (br && br_flag)) begin
               ALUSrcA = SRC_PC;     ALUSrcB = SRC_IMMED;
            end else begin
               ALUSrcA = SRC_PC;     ALUSrcB = SRC_CONST4;
            end
            memReq    = ld || sto;
            DMemRead  = ld;
            DMemWrite = sto;
         end
         S_WRITEBACK: begin
            PCWrite         = 1'b1;
            regFileWrite    = !(sto || br || illegal);
            regFileWriteSrc = ld;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
      // Reset kills every output combinationally so an in-flight access drops at once.
      if (!rst_n) begin
         memReq = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0; DMemRead = 1'b0; DMemWrite = 1'b0;
         ALUOverride = 1'b0; regFileWrite = 1'b0; ALUSrcA = SRC_REGOUT; ALUSrcB = SRC_REGOUT;
         regFileWriteSrc = 1'b0; trap = 1'b0;
      end
   end

   assign timeout = memReq && !memReady && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= S_FETCH;
         br_flag  <= 1'b0;
         wait_cnt <= 8'd0;
         instret  <= '0;
      end else begin
         wait_cnt <= (memReq && !memReady) ? wait_cnt + 8'd1 : 8'd0;
         case (st)
            S_FETCH: begin
               if (memReady)     st <= S_DECODE;
               else if (timeout) st <= S_TRAP;
            end
            S_DECODE: st <= (illegal && TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
               br_flag <= branchTaken;
               st      <= S_MEMORY;
            end
            S_MEMORY: begin
               if (!(ld || sto) || memReady) st <= S_WRITEBACK;
               else if (timeout)             st <= S_TRAP;
            end
            S_WRITEBACK: begin
               instret <= instret + INSTRET_WIDTH'(1);
               st      <= S_FETCH;
            end
            S_TRAP:  st <= S_TRAP;
            default: st <= S_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: two instances differing only in illegal-encoding policy.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
   localparam logic [6:0] OP_ALU_REG = 7'b0110011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opCode;
   logic [2:0] funct3;
   logic       branchTaken;
   logic       memReady;

   logic       memReq, PCWrite, IRWrite, DMemRead, DMemWrite, ALUOverride, regFileWrite;
   logic [1:0] ALUSrcA, ALUSrcB;
   logic       regFileWriteSrc, trap;
   logic [2:0] state;
   logic [3:0] instret;

   logic       b_memReq, b_PCWrite, b_IRWrite, b_DMemRead, b_DMemWrite, b_ALUOverride, b_regFileWrite;
   logic [1:0] b_ALUSrcA, b_ALUSrcB;
   logic       b_regFileWriteSrc, b_trap;
   logic [2:0] b_state;
   logic [3:0] b_instret;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.INSTRET_WIDTH(4), .TIMEOUT_CYCLES(4), .TRAP_ON_ILLEGAL(1)) dut (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3), .branchTaken(branchTaken),
      .memReady(memReady), .memReq(memReq), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .DMemRead(DMemRead), .DMemWrite(DMemWrite), .ALUOverride(ALUOverride),
      .regFileWrite(regFileWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .regFileWriteSrc(regFileWriteSrc), .trap(trap), .state(state), .instret(instret));

   multicycle_controller #(.INSTRET_WIDTH(4), .TIMEOUT_CYCLES(4), .TRAP_ON_ILLEGAL(0)) dut_nop (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3), .branchTaken(branchTaken),
      .memReady(memReady), .memReq(b_memReq), .PCWrite(b_PCWrite), .IRWrite(b_IRWrite),
      .DMemRead(b_DMemRead), .DMemWrite(b_DMemWrite), .ALUOverride(b_ALUOverride),
      .regFileWrite(b_regFileWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
      .regFileWriteSrc(b_regFileWriteSrc), .trap(b_trap), .state(b_state), .instret(b_instret));

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_chk++;
      assert (obs === 32'(exp)) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; opCode = OP_ALU_REG; funct3 = 3'd0; branchTaken = 1'b0; memReady = 1'b1;
      #3;
      chk("rst_state",   32'(state), 0);
      chk("rst_memReq",  32'(memReq), 0);
      chk("rst_IRWrite", 32'(IRWrite), 0);
      chk("rst_trap",    32'(trap), 0);
      chk("rst_instret", 32'(instret), 0);
      chk("rst_srcA",    32'(ALUSrcA), 0);
      chk("rst_srcB",    32'(ALUSrcB), 0);

      // ALU_REG with memReady always high
      adv; rst_n = 1'b1; #1;
      chk("alu_f_state",   32'(state), 0);
      chk("alu_f_memReq",  32'(memReq), 1);
      chk("alu_f_IRWrite", 32'(IRWrite), 1);
      adv; chk("alu_d_state", 32'(state), 1);
      adv; chk("alu_e_state", 32'(state), 2);
      chk("alu_e_srcA", 32'(ALUSrcA), 0);
      chk("alu_e_srcB", 32'(ALUSrcB), 0);
      adv; chk("alu_m_state", 32'(state), 3);
      chk("alu_m_ovr",  32'(ALUOverride), 1);
      chk("alu_m_srcA", 32'(ALUSrcA), 1);
      chk("alu_m_srcB", 32'(ALUSrcB), 2);
      adv; chk("alu_w_state", 32'(state), 4);
      chk("alu_w_PCWrite", 32'(PCWrite), 1);
      chk("alu_w_rfw",     32'(regFileWrite), 1);
      chk("alu_w_rfsrc",   32'(regFileWriteSrc), 0);
      adv; chk("alu_instret", 32'(instret), 1);
      chk("alu_back_fetch", 32'(state), 0);

      // LOAD lw with three stalled MEMORY cycles
      opCode = OP_LOAD; funct3 = 3'd2;
      adv; chk("ld_d_state", 32'(state), 1);
      adv; chk("ld_e_srcB", 32'(ALUSrcB), 1);
      memReady = 1'b0;
      adv; chk("ld_m1_state", 32'(state), 3); chk("ld_m1_rd", 32'(DMemRead), 1);
      chk("ld_m1_req", 32'(memReq), 1);
      adv; chk("ld_m2_state", 32'(state), 3); chk("ld_m2_rd", 32'(DMemRead), 1);
      adv; chk("ld_m3_state", 32'(state), 3); chk("ld_m3_rd", 32'(DMemRead), 1);
      adv; memReady = 1'b1; #1;
      chk("ld_m4_state", 32'(state), 3); chk("ld_m4_rd", 32'(DMemRead), 1);
      adv; chk("ld_w_state", 32'(state), 4);
      chk("ld_w_rfsrc", 32'(regFileWriteSrc), 1);
      chk("ld_w_rfw",   32'(regFileWrite), 1);
      chk("ld_w_trap",  32'(trap), 0);
      adv; chk("ld_instret", 32'(instret), 2);

      // BRANCH taken, then not taken
      opCode = OP_BRANCH; funct3 = 3'd0; branchTaken = 1'b1;
      adv; adv;
      chk("bt_e_srcA", 32'(ALUSrcA), 0); chk("bt_e_srcB", 32'(ALUSrcB), 0);
      adv; branchTaken = 1'b0; #1;
      chk("bt_m_srcA", 32'(ALUSrcA), 1); chk("bt_m_srcB", 32'(ALUSrcB), 1);
      adv; chk("bt_w_rfw", 32'(regFileWrite), 0); chk("bt_w_pcw", 32'(PCWrite), 1);
      adv; chk("bt_instret", 32'(instret), 3);
      adv; adv; adv;
      chk("bn_m_srcA", 32'(ALUSrcA), 1); chk("bn_m_srcB", 32'(ALUSrcB), 2);
      adv; memReady = 1'b0; #1;
      chk("bn_w_rfw", 32'(regFileWrite), 0);

      // FETCH wait, ready on the 4th wait cycle
      adv; opCode = OP_ALU_IMM;
      chk("bn_instret", 32'(instret), 4);
      chk("fw1_state", 32'(state), 0); chk("fw1_ir", 32'(IRWrite), 0);
      adv; chk("fw2_state", 32'(state), 0);
      adv; chk("fw3_state", 32'(state), 0);
      adv; memReady = 1'b1; #1;
      chk("fw4_state", 32'(state), 0); chk("fw4_ir", 32'(IRWrite), 1);
      adv; chk("fw_decode", 32'(state), 1); chk("fw_trap", 32'(trap), 0);
      adv; chk("imm_e_srcA", 32'(ALUSrcA), 0); chk("imm_e_srcB", 32'(ALUSrcB), 1);
      adv; adv; memReady = 1'b0;

      // FETCH timeout
      adv; chk("to_instret", 32'(instret), 5);
      chk("to1_ir", 32'(IRWrite), 0);
      adv; chk("to2_ir", 32'(IRWrite), 0);
      adv; chk("to3_ir", 32'(IRWrite), 0);
      adv; chk("to4_state", 32'(state), 0); chk("to4_ir", 32'(IRWrite), 0);
      adv; chk("to_state", 32'(state), 5); chk("to_trap", 32'(trap), 1);
      chk("to_memReq", 32'(memReq), 0); chk("to_ir", 32'(IRWrite), 0);
      adv; chk("to_hold", 32'(state), 5); chk("to_frozen", 32'(instret), 5);

      // Illegal STORE funct3=5 under both policies
      rst_n = 1'b0; #1;
      chk("rst2_state", 32'(state), 0); chk("rst2_trap", 32'(trap), 0);
      chk("rst2_instret", 32'(instret), 0); chk("rst2_b_trap", 32'(b_trap), 0);
      adv; rst_n = 1'b1; opCode = OP_STORE; funct3 = 3'd5; memReady = 1'b1;
      adv; chk("il_d_state", 32'(state), 1);
      adv; chk("il_trap_state", 32'(state), 5); chk("il_trap", 32'(trap), 1);
      chk("il_b_state", 32'(b_state), 2);
      adv; chk("il_b_m_state", 32'(b_state), 3); chk("il_b_m_wr", 32'(b_DMemWrite), 0);
      chk("il_b_m_req", 32'(b_memReq), 0);
      adv; chk("il_b_w_pcw", 32'(b_PCWrite), 1); chk("il_b_w_rfw", 32'(b_regFileWrite), 0);
      chk("il_b_w_wr", 32'(b_DMemWrite), 0);
      adv; chk("il_b_instret", 32'(b_instret), 1); chk("il_a_frozen", 32'(instret), 0);

      // Reset in the middle of a stalled STORE
      rst_n = 1'b0; #1;
      adv; rst_n = 1'b1; opCode = OP_STORE; funct3 = 3'd2; memReady = 1'b1;
      adv; adv; memReady = 1'b0;
      adv; chk("st_m1_state", 32'(state), 3); chk("st_m1_wr", 32'(DMemWrite), 1);
      chk("st_m1_req", 32'(memReq), 1);
      adv; chk("st_m2_wr", 32'(DMemWrite), 1);
      #2; rst_n = 1'b0; #1;
      chk("st_rst_wr", 32'(DMemWrite), 0); chk("st_rst_req", 32'(memReq), 0);
      chk("st_rst_state", 32'(state), 0); chk("st_rst_b_wr", 32'(b_DMemWrite), 0);
      adv; rst_n = 1'b1; memReady = 1'b1; opCode = OP_ALU_REG; funct3 = 3'd0; #1;
      chk("st_rel_state", 32'(state), 0); chk("st_rel_instret", 32'(instret), 0);
      chk("st_rel_memReq", 32'(memReq), 1);

      // 16 retirements wrap the 4-bit counter
      for (int i = 1; i <= 16; i++) begin
         repeat (5) adv;
         chk("wrap_instret", 32'(instret), i & 15);
      end
      chk("wrap_state", 32'(state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
